music_player_ctrl: RTL and testbench



---
 rtl/music_player_ctrl_if.sv | 26 ++
 rtl/music_player_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_music_player_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/music_player_ctrl_if.sv
// Keypad/sequencer connection of the music player controller.
// master = keypad/sequencer side, slave = controller side.
interface music_player_ctrl_if #(
   parameter int SONG_W  = 2,
   parameter int SPEED_W = 2
);
   logic [3:0]         key;
   logic               pressed;
   logic               song_done;
   logic [SONG_W-1:0]  song_sel;
   logic               play_en;
   logic               run;
   logic [SPEED_W-1:0] speed_sel;
   logic               menu_ctl;
   logic               song_start;

   modport master (
      output key, pressed, song_done,
      input  song_sel, play_en, run, speed_sel, menu_ctl, song_start
   );

   modport slave (
      input  key, pressed, song_done,
      output song_sel, play_en, run, speed_sel, menu_ctl, song_start
   );
endinterface

// File: rtl/music_player_ctrl.sv
// Keypad-driven playback controller: song select, next/prev with wrap,
// pause, tempo mode and end-of-song handling, with registered outputs.
module music_player_ctrl #(
   parameter int NUM_SONGS     = 4,
   parameter int SONG_W        = 2,
   parameter int NUM_SPEEDS    = 3,
   parameter int SPEED_W       = 2,
   parameter int DEFAULT_SPEED = 1,
   parameter int AUTO_ADVANCE  = 1,
   parameter int KEY_MENU      = 11,
   parameter int KEY_PAUSE     = 12,
   parameter int KEY_SPEED     = 13,
   parameter int KEY_NEXT      = 14,
   parameter int KEY_PREV      = 15
) (
   input  logic              clk,
   input  logic              rst,
   music_player_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_MENU  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_SPEED = 2'd3
   } state_e;

   localparam logic [3:0]         K_MENU    = 4'(KEY_MENU);
   localparam logic [3:0]         K_PAUSE   = 4'(KEY_PAUSE);
   localparam logic [3:0]         K_SPEED   = 4'(KEY_SPEED);
   localparam logic [3:0]         K_NEXT    = 4'(KEY_NEXT);
   localparam logic [3:0]         K_PREV    = 4'(KEY_PREV);
   localparam logic [3:0]         K_SONGS   = 4'(NUM_SONGS);
   localparam logic [3:0]         K_SPEEDS  = 4'(NUM_SPEEDS);
   localparam logic [SONG_W-1:0]  SONG_LAST = SONG_W'(NUM_SONGS - 1);
   localparam logic [SONG_W-1:0]  SONG_ZERO = SONG_W'(0);
   localparam logic [SONG_W-1:0]  SONG_ONE  = SONG_W'(1);
   localparam logic [SPEED_W-1:0] SPEED_RST = SPEED_W'(DEFAULT_SPEED);

   // Explicit compare keeps the wrap correct for non power-of-two song counts.
   function automatic logic [SONG_W-1:0] next_song(input logic [SONG_W-1:0] s);
      return (s == SONG_LAST) ? SONG_ZERO : s + SONG_ONE;
   endfunction

   function automatic logic [SONG_W-1:0] prev_song(input logic [SONG_W-1:0] s);
      return (s == SONG_ZERO) ? SONG_LAST : s - SONG_ONE;
   endfunction

   state_e             state_q, state_d;
   logic [SONG_W-1:0]  song_q, song_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               play_en_q, play_en_d;
   logic               run_q, run_d;
   logic               menu_q, menu_d;
   logic               start_q, start_d;

   logic               load_s;
   logic               is_song_s;
   logic               is_speed_s;
   logic [SONG_W-1:0]  key_song_s;
   logic [SPEED_W-1:0] key_speed_s;
   state_e             done_state_s;
   logic [SONG_W-1:0]  done_song_s;
   logic               done_load_s;

   assign is_song_s    = (bus.key != 4'd0) && (bus.key <= K_SONGS);
   assign is_speed_s   = (bus.key != 4'd0) && (bus.key <= K_SPEEDS);
   assign key_song_s   = SONG_W'(bus.key - 4'd1);
   assign key_speed_s  = SPEED_W'(bus.key - 4'd1);
   assign done_state_s = (AUTO_ADVANCE != 0) ? ST_PLAY : ST_MENU;
   assign done_song_s  = (AUTO_ADVANCE != 0) ? next_song(song_q) : song_q;
   assign done_load_s  = (AUTO_ADVANCE != 0);

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_MENU;
         song_q    <= SONG_ZERO;
         speed_q   <= SPEED_RST;
         play_en_q <= 1'b0;
         run_q     <= 1'b1;
         menu_q    <= 1'b1;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         song_q    <= song_d;
         speed_q   <= speed_d;
         play_en_q <= play_en_d;
         run_q     <= run_d;
         menu_q    <= menu_d;
         start_q   <= start_d;
      end
   end

   // Next-state logic; a key strobe always wins over a same-cycle song_done.
   always_comb begin
      state_d = state_q;
      song_d  = song_q;
      speed_d = speed_q;
      load_s  = 1'b0;
      case (state_q)
         ST_MENU: begin
            if (bus.pressed && is_song_s) begin
               state_d = ST_PLAY;
               song_d  = key_song_s;
               load_s  = 1'b1;
            end else begin
               state_d = ST_MENU;
            end
         end
         ST_PLAY: begin
            if (bus.pressed) begin
               if (is_song_s) begin
                  song_d = key_song_s;
                  load_s = 1'b1;
               end else if (bus.key == K_NEXT) begin
                  song_d = next_song(song_q);
                  load_s = 1'b1;
               end else if (bus.key == K_PREV) begin
                  song_d = prev_song(song_q);
                  load_s = 1'b1;
               end else if (bus.key == K_PAUSE) begin
                  state_d = ST_PAUSE;
               end else if (bus.key == K_SPEED) begin
                  state_d = ST_SPEED;
               end else if (bus.key == K_MENU) begin
                  state_d = ST_MENU;
               end else begin
                  state_d = ST_PLAY;
               end
            end else if (bus.song_done) begin
               state_d = done_state_s;
               song_d  = done_song_s;
               load_s  = done_load_s;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_PAUSE: begin
            if (bus.pressed && (bus.key == K_PAUSE)) begin
               state_d = ST_PLAY;
            end else if (bus.pressed && (bus.key == K_MENU)) begin
               state_d = ST_MENU;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_SPEED: begin
            if (bus.pressed) begin
               if (is_speed_s) begin
                  speed_d = key_speed_s;
                  state_d = ST_PLAY;
               end else if (bus.key == K_SPEED) begin
                  state_d = ST_PLAY;
               end else if (bus.key == K_MENU) begin
                  state_d = ST_MENU;
               end else begin
                  state_d = ST_SPEED;
               end
            end else if (bus.song_done) begin
               state_d = done_state_s;
               song_d  = done_song_s;
               load_s  = done_load_s;
            end else begin
               state_d = ST_SPEED;
            end
         end
         default: begin
            state_d = ST_MENU;
            song_d  = SONG_ZERO;
            load_s  = 1'b0;
         end
      endcase
   end

   // Output decode from the upcoming state so outputs track it after the edge.
   always_comb begin
      play_en_d = 1'b0;
      run_d     = 1'b1;
      menu_d    = 1'b1;
      start_d   = load_s;
      case (state_d)
         ST_MENU: begin
            play_en_d = 1'b0;
            run_d     = 1'b1;
            menu_d    = 1'b1;
         end
         ST_PLAY, ST_SPEED: begin
            play_en_d = 1'b1;
            run_d     = 1'b1;
            menu_d    = 1'b0;
         end
         ST_PAUSE: begin
            play_en_d = 1'b1;
            run_d     = 1'b0;
            menu_d    = 1'b0;
         end
         default: begin
            play_en_d = 1'b0;
            run_d     = 1'b1;
            menu_d    = 1'b1;
            start_d   = 1'b0;
         end
      endcase
   end

   assign bus.song_sel   = song_q;
   assign bus.play_en    = play_en_q;
   assign bus.run        = run_q;
   assign bus.speed_sel  = speed_q;
   assign bus.menu_ctl   = menu_q;
   assign bus.song_start = start_q;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Table-driven bench for music_player_ctrl: instance A auto-advances,
// instance B returns to the menu at end of song.
module tb_music_player_ctrl;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   music_player_ctrl_if #(.SONG_W(2), .SPEED_W(2)) bus_a ();
   music_player_ctrl_if #(.SONG_W(2), .SPEED_W(2)) bus_b ();

   music_player_ctrl #(
      .NUM_SONGS(4), .SONG_W(2), .NUM_SPEEDS(3), .SPEED_W(2), .DEFAULT_SPEED(1),
      .AUTO_ADVANCE(1), .KEY_MENU(11), .KEY_PAUSE(12), .KEY_SPEED(13),
      .KEY_NEXT(14), .KEY_PREV(15)
   ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));

   music_player_ctrl #(
      .NUM_SONGS(4), .SONG_W(2), .NUM_SPEEDS(3), .SPEED_W(2), .DEFAULT_SPEED(1),
      .AUTO_ADVANCE(0), .KEY_MENU(11), .KEY_PAUSE(12), .KEY_SPEED(13),
      .KEY_NEXT(14), .KEY_PREV(15)
   ) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

   // expected = {song_sel[1:0], play_en, run, speed_sel[1:0], menu_ctl, song_start}
   typedef struct {
      logic       r;
      logic       p;
      logic [3:0] k;
      logic       d;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl_a[$];
   vec_t tbl_b[$];

   function automatic vec_t v(input logic r, input logic p, input logic [3:0] k, input logic d,
                              input logic [1:0] s, input logic pl, input logic ru,
                              input logic [1:0] sp, input logic m, input logic st);
      vec_t x;
      x.r   = r;
      x.p   = p;
      x.k   = k;
      x.d   = d;
      x.exp = {s, pl, ru, sp, m, st};
      return x;
   endfunction

   function automatic logic [7:0] obs_a();
      return {bus_a.song_sel, bus_a.play_en, bus_a.run, bus_a.speed_sel, bus_a.menu_ctl, bus_a.song_start};
   endfunction

   function automatic logic [7:0] obs_b();
      return {bus_b.song_sel, bus_b.play_en, bus_b.run, bus_b.speed_sel, bus_b.menu_ctl, bus_b.song_start};
   endfunction

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] actual=%b expected=%b (song,play,run,spd,menu,start)", name, idx, act, exp);
      end
   endtask

   initial begin
      bus_a.key = 4'd0; bus_a.pressed = 1'b0; bus_a.song_done = 1'b0;
      bus_b.key = 4'd0; bus_b.pressed = 1'b0; bus_b.song_done = 1'b0;

      //             r  p  k   d   song pl ru spd m  st
      tbl_a.push_back(v(1, 0, 0,  0, 2'd0, 0, 1, 2'd1, 1, 0));
      tbl_a.push_back(v(0, 0, 0,  0, 2'd0, 0, 1, 2'd1, 1, 0));
      tbl_a.push_back(v(0, 1, 0,  0, 2'd0, 0, 1, 2'd1, 1, 0));
      tbl_a.push_back(v(0, 1, 9,  0, 2'd0, 0, 1, 2'd1, 1, 0));
      tbl_a.push_back(v(0, 1, 11, 0, 2'd0, 0, 1, 2'd1, 1, 0));
      tbl_a.push_back(v(0, 0, 0,  1, 2'd0, 0, 1, 2'd1, 1, 0));
      tbl_a.push_back(v(0, 1, 2,  0, 2'd1, 1, 1, 2'd1, 0, 1));
      tbl_a.push_back(v(0, 0, 0,  0, 2'd1, 1, 1, 2'd1, 0, 0));
      tbl_a.push_back(v(0, 1, 4,  0, 2'd3, 1, 1, 2'd1, 0, 1));
      tbl_a.push_back(v(0, 1, 14, 0, 2'd0, 1, 1, 2'd1, 0, 1));
      tbl_a.push_back(v(0, 1, 15, 0, 2'd3, 1, 1, 2'd1, 0, 1));
      tbl_a.push_back(v(0, 1, 15, 0, 2'd2, 1, 1, 2'd1, 0, 1));
      tbl_a.push_back(v(0, 1, 3,  0, 2'd2, 1, 1, 2'd1, 0, 1));
      tbl_a.push_back(v(0, 1, 12, 0, 2'd2, 1, 0, 2'd1, 0, 0));
      tbl_a.push_back(v(0, 1, 3,  0, 2'd2, 1, 0, 2'd1, 0, 0));
      tbl_a.push_back(v(0, 1, 14, 0, 2'd2, 1, 0, 2'd1, 0, 0));
      tbl_a.push_back(v(0, 0, 0,  1, 2'd2, 1, 0, 2'd1, 0, 0));
      tbl_a.push_back(v(0, 1, 12, 0, 2'd2, 1, 1, 2'd1, 0, 0));
      tbl_a.push_back(v(0, 1, 13, 0, 2'd2, 1, 1, 2'd1, 0, 0));
      tbl_a.push_back(v(0, 1, 3,  0, 2'd2, 1, 1, 2'd2, 0, 0));
      tbl_a.push_back(v(0, 1, 13, 0, 2'd2, 1, 1, 2'd2, 0, 0));
      tbl_a.push_back(v(0, 1, 13, 0, 2'd2, 1, 1, 2'd2, 0, 0));
      tbl_a.push_back(v(0, 1, 13, 0, 2'd2, 1, 1, 2'd2, 0, 0));
      tbl_a.push_back(v(0, 1, 1,  0, 2'd2, 1, 1, 2'd0, 0, 0));
      tbl_a.push_back(v(0, 1, 13, 0, 2'd2, 1, 1, 2'd0, 0, 0));
      tbl_a.push_back(v(0, 0, 0,  1, 2'd3, 1, 1, 2'd0, 0, 1));
      tbl_a.push_back(v(0, 1, 2,  0, 2'd1, 1, 1, 2'd0, 0, 1));
      tbl_a.push_back(v(0, 0, 0,  1, 2'd2, 1, 1, 2'd0, 0, 1));
      tbl_a.push_back(v(0, 1, 4,  0, 2'd3, 1, 1, 2'd0, 0, 1));
      tbl_a.push_back(v(0, 0, 0,  1, 2'd0, 1, 1, 2'd0, 0, 1));
      tbl_a.push_back(v(0, 1, 12, 1, 2'd0, 1, 0, 2'd0, 0, 0));
      tbl_a.push_back(v(0, 1, 11, 0, 2'd0, 0, 1, 2'd0, 1, 0));
      tbl_a.push_back(v(0, 0, 0,  1, 2'd0, 0, 1, 2'd0, 1, 0));
      tbl_a.push_back(v(0, 1, 3,  0, 2'd2, 1, 1, 2'd0, 0, 1));
      tbl_a.push_back(v(0, 1, 13, 0, 2'd2, 1, 1, 2'd0, 0, 0));
      tbl_a.push_back(v(0, 1, 3,  0, 2'd2, 1, 1, 2'd2, 0, 0));
      tbl_a.push_back(v(0, 1, 13, 0, 2'd2, 1, 1, 2'd2, 0, 0));
      tbl_a.push_back(v(1, 1, 1,  0, 2'd0, 0, 1, 2'd1, 1, 0));
      tbl_a.push_back(v(0, 1, 2,  0, 2'd1, 1, 1, 2'd1, 0, 1));
      tbl_a.push_back(v(0, 1, 2,  0, 2'd1, 1, 1, 2'd1, 0, 1));
      tbl_a.push_back(v(0, 1, 0,  0, 2'd1, 1, 1, 2'd1, 0, 0));
      tbl_a.push_back(v(0, 1, 11, 0, 2'd1, 0, 1, 2'd1, 1, 0));
      tbl_a.push_back(v(0, 1, 14, 0, 2'd1, 0, 1, 2'd1, 1, 0));

      // AUTO_ADVANCE=0 corner sequence
      tbl_b.push_back(v(1, 0, 0,  0, 2'd0, 0, 1, 2'd1, 1, 0));
      tbl_b.push_back(v(0, 1, 4,  0, 2'd3, 1, 1, 2'd1, 0, 1));
      tbl_b.push_back(v(0, 0, 0,  1, 2'd3, 0, 1, 2'd1, 1, 0));
      tbl_b.push_back(v(0, 1, 1,  0, 2'd0, 1, 1, 2'd1, 0, 1));
      tbl_b.push_back(v(0, 1, 13, 0, 2'd0, 1, 1, 2'd1, 0, 0));
      tbl_b.push_back(v(0, 1, 4,  0, 2'd0, 1, 1, 2'd1, 0, 0));
      tbl_b.push_back(v(0, 1, 3,  0, 2'd0, 1, 1, 2'd2, 0, 0));
      tbl_b.push_back(v(0, 1, 13, 0, 2'd0, 1, 1, 2'd2, 0, 0));
      tbl_b.push_back(v(0, 0, 0,  1, 2'd0, 0, 1, 2'd2, 1, 0));
      tbl_b.push_back(v(0, 1, 2,  0, 2'd1, 1, 1, 2'd2, 0, 1));
      tbl_b.push_back(v(0, 1, 12, 1, 2'd1, 1, 0, 2'd2, 0, 0));

      for (int i = 0; i < tbl_a.size(); i++) begin
         @(negedge clk);
         rst_a           = tbl_a[i].r;
         bus_a.pressed   = tbl_a[i].p;
         bus_a.key       = tbl_a[i].k;
         bus_a.song_done = tbl_a[i].d;
         @(posedge clk);
         #1;
         check("auto_vec", i, obs_a(), tbl_a[i].exp);
      end

      for (int i = 0; i < tbl_b.size(); i++) begin
         @(negedge clk);
         rst_b           = tbl_b[i].r;
         bus_b.pressed   = tbl_b[i].p;
         bus_b.key       = tbl_b[i].k;
         bus_b.song_done = tbl_b[i].d;
         @(posedge clk);
         #1;
         check("menu_vec", i, obs_b(), tbl_b[i].exp);
      end

      // idle cycle after the last load: song_start must have dropped
      @(negedge clk);
      bus_b.pressed   = 1'b0;
      bus_b.song_done = 1'b0;
      bus_b.key       = 4'd0;
      @(posedge clk);
      #1;
      check("menu_idle", 0, obs_b(), {2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
